// File: rtl/bcd_price_cmp_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_price_cmp_arb (+ bcd_pkg)
//  Description : Round-robin arbiter that shares one digit-serial BCD price
//                comparator between N_REQ requesters. Walks the five BCD
//                digits MSB-first with early exit on the first difference and
//                returns {id, lt, eq, gt, err} on a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================

package bcd_pkg;
   // {dollar[2], dollar[1], dollar[0], cents[1], cents[0]}, 4 bits per digit
   typedef logic [19:0] price_t;
endpackage

module bcd_price_cmp_arb #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_vld,
   input  logic [N_REQ*20-1:0]   req_a,
   input  logic [N_REQ*20-1:0]   req_b,
   output logic [N_REQ-1:0]      req_rdy,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_lt,
   output logic                  rsp_eq,
   output logic                  rsp_gt,
   output logic                  rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   localparam logic [ID_W:0] C_NREQ = (ID_W+1)'(N_REQ);

   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [2:0]      idx_q, idx_d;
   bcd_pkg::price_t a_q, a_d;
   bcd_pkg::price_t b_q, b_d;
   logic            lt_q, lt_d;
   logic            eq_q, eq_d;
   logic            gt_q, gt_d;
   logic            err_q, err_d;

   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W:0]   cand;
   bcd_pkg::price_t sel_a, sel_b;
   logic            sel_err;
   logic [3:0]      a_dig, b_dig;

   // True when any nibble of the price is not a legal BCD digit.
   function automatic logic has_bad_digit(input bcd_pkg::price_t p);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (p[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Round-robin search: first valid requester starting just after ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (cand >= C_NREQ) cand = cand - C_NREQ;
         if (!gnt_found && req_vld[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Operand mux for the winning requester plus BCD legality check.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_a = req_a[20*i +: 20];
            sel_b = req_b[20*i +: 20];
         end
      end
      sel_err = has_bad_digit(sel_a) | has_bad_digit(sel_b);
   end

   // Pick the digit currently under comparison (idx 4 = most significant).
   always_comb begin
      case (idx_q)
         3'd4:    begin a_dig = a_q[19:16]; b_dig = b_q[19:16]; end
         3'd3:    begin a_dig = a_q[15:12]; b_dig = b_q[15:12]; end
         3'd2:    begin a_dig = a_q[11:8];  b_dig = b_q[11:8];  end
         3'd1:    begin a_dig = a_q[7:4];   b_dig = b_q[7:4];   end
         default: begin a_dig = a_q[3:0];   b_dig = b_q[3:0];   end
      endcase
   end

   // Sequencer: accept in IDLE, one digit per cycle in CMP, hold result in RSP.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      err_d   = err_q;
      req_rdy = '0;
      case (state_q)
         S_IDLE: begin
            // Grant is suppressed during reset so no requester sees a phantom accept.
            if (gnt_found && !rst) begin
               req_rdy[gnt_idx] = 1'b1;
               a_d     = sel_a;
               b_d     = sel_b;
               id_d    = gnt_idx;
               ptr_d   = gnt_idx;
               idx_d   = 3'd4;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               err_d   = sel_err;
               state_d = sel_err ? S_RSP : S_CMP;
            end
         end
         S_CMP: begin
            if (a_dig < b_dig) begin
               lt_d    = 1'b1;
               state_d = S_RSP;
            end else if (a_dig > b_dig) begin
               gt_d    = 1'b1;
               state_d = S_RSP;
            end else if (idx_q == 3'd0) begin
               eq_d    = 1'b1;
               state_d = S_RSP;
            end else begin
               idx_d   = idx_q - 3'd1;
            end
         end
         S_RSP: begin
            if (rsp_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; ptr resets so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= ID_W'(N_REQ-1);
         id_q    <= '0;
         idx_q   <= 3'd4;
         a_q     <= '0;
         b_q     <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         err_q   <= err_d;
      end
   end

   assign rsp_vld = (state_q == S_RSP);
   assign rsp_id  = id_q;
   assign rsp_lt  = lt_q;
   assign rsp_eq  = eq_q;
   assign rsp_gt  = gt_q;
   assign rsp_err = err_q;

endmodule

`default_nettype wire
